// File: rtl/spi_master_if.sv
// Parallel write port and SPI pin bundle for spi_master.
interface spi_master_if #(
    parameter int unsigned width      = 16,
    parameter int unsigned fifo_depth = 4
);
    localparam int unsigned LVL_W = $clog2(fifo_depth) + 1;

    logic [width-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;
    logic             nCS;
    logic             SCK;
    logic             MOSI;

    modport master (
        input  wr_data, wr_valid,
        output wr_ready, fifo_level, busy, nCS, SCK, MOSI
    );

    modport slave (
        output wr_data, wr_valid,
        input  wr_ready, fifo_level, busy, nCS, SCK, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 write-only master: frame FIFO feeding an MSB-first shifter
// with registered nCS/SCK/MOSI and a programmable SCK half-period.
module spi_master #(
    parameter int unsigned width      = 16,
    parameter int unsigned clk_div    = 4,
    parameter int unsigned fifo_depth = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam int unsigned BIT_W = (width > 1) ? $clog2(width) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(clk_div - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(width - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(fifo_depth);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_t;

    // Frame FIFO
    logic [width-1:0] mem [fifo_depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic [LVL_W-1:0] count_next;
    logic             ready_r;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign full       = (count == LVL_FULL);
    assign empty      = (count == '0);
    assign push       = bus.wr_valid && !full;
    assign count_next = count + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_r <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            ready_r <= (count_next != LVL_FULL);
        end
    end

    // Shift FSM
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_next;
    logic [width-1:0] shift;
    logic [width-1:0] shift_next;
    logic             ncs_r;
    logic             sck_r;
    logic             mosi_r;
    logic             busy_r;
    logic             ncs_next;
    logic             sck_next;
    logic             mosi_next;
    logic             busy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            ncs_r   <= 1'b1;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            ncs_r   <= ncs_next;
            sck_r   <= sck_next;
            mosi_r  <= mosi_next;
            busy_r  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = '0;
                    cnt_next   = CNT_LOAD;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_next   = CNT_LOAD;
                    state_next = SHIFT_HI;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            SHIFT_HI: begin
                if (cnt == '0) begin
                    cnt_next   = CNT_LOAD;
                    shift_next = shift << 1;
                    state_next = SHIFT_LO;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            SHIFT_LO: begin
                if (cnt == '0) begin
                    cnt_next = CNT_LOAD;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = GAP;
                    end else begin
                        bit_next   = bit_cnt + BIT_W'(1);
                        state_next = SHIFT_HI;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        bit_next   = '0;
                        cnt_next   = CNT_LOAD;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Pin values are registered from the state being entered
        ncs_next  = !((state_next == SETUP) || (state_next == SHIFT_HI) ||
                      (state_next == SHIFT_LO));
        sck_next  = (state_next == SHIFT_HI);
        busy_next = (state_next != IDLE);
        case (state_next)
            SETUP:    mosi_next = shift_next[width-1];
            SHIFT_HI: mosi_next = mosi_r;
            SHIFT_LO: mosi_next = ((state == SHIFT_HI) && (bit_cnt != BIT_LAST)) ?
                                  shift_next[width-1] : mosi_r;
            default:  mosi_next = 1'b0;
        endcase
    end

    assign bus.wr_ready   = ready_r;
    assign bus.fifo_level = count;
    assign bus.busy       = busy_r;
    assign bus.nCS        = ncs_r;
    assign bus.SCK        = sck_r;
    assign bus.MOSI       = mosi_r;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: a slave model on each SPI port decodes
// frames and timing; stimulus queues the frames each port should deliver.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master_if #(.width(16), .fifo_depth(4)) ifa ();
    spi_master_if #(.width(8),  .fifo_depth(4)) ifb ();

    spi_master #(.width(16), .clk_div(2), .fifo_depth(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master)
    );
    spi_master #(.width(8), .clk_div(1), .fifo_depth(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master)
    );

    typedef struct {
        logic        psck;
        logic        pncs;
        logic        pmosi;
        int          low;
        int          rises;
        int          high;
        int          last_gap;
        int          frames;
        logic [15:0] sh;
        logic [31:0] map;
        logic [31:0] last_map;
    } mon_t;

    mon_t        mon_a;
    mon_t        mon_b;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    logic        allow_abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic mon_init(output mon_t m);
        m.psck = 1'b0; m.pncs = 1'b1; m.pmosi = 1'b0;
        m.low = 0; m.rises = 0; m.high = 0; m.last_gap = 0; m.frames = 0;
        m.sh = '0; m.map = '0; m.last_map = '0;
    endtask

    // Slave model: samples pins once per cycle, decodes a frame on nCS rise
    task automatic mon_tick(inout mon_t m, input int w, input int div,
                            input logic ncs, input logic sck, input logic mosi,
                            output logic done, output logic [15:0] data);
        done = 1'b0;
        data = m.sh;
        if (m.psck && sck) chk("mosi_stable_while_sck_high", 32'(mosi), 32'(m.pmosi));
        if (!m.psck && sck) chk("sck_rise_needs_ncs_low", 32'(ncs), 32'd0);
        if (!ncs) begin
            if (m.pncs) begin
                m.last_gap = m.high;
                m.low = 0; m.rises = 0; m.sh = '0; m.map = '0;
            end
            if (sck && m.low < 32) m.map[m.low] = 1'b1;
            if (!m.psck && sck) begin
                m.sh = {m.sh[14:0], mosi};
                m.rises++;
            end
            m.low++;
        end else begin
            if (!m.pncs) begin
                if (!(allow_abort && m.rises != w)) begin
                    chk("ncs_low_cycles", 32'(m.low), 32'(div * (2 * w + 1)));
                    chk("sck_rises_per_frame", 32'(m.rises), 32'(w));
                    done = (m.rises == w);
                    data = m.sh;
                    m.last_map = m.map;
                    m.frames++;
                end
                m.high = 0;
            end
            m.high++;
        end
        m.psck = sck; m.pncs = ncs; m.pmosi = mosi;
    endtask

    always @(negedge clk) begin
        logic        done;
        logic [15:0] d;
        mon_tick(mon_a, 16, 2, ifa.nCS, ifa.SCK, ifa.MOSI, done, d);
        if (done) begin
            if (exp_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL frame_a: got 0x%0h, expected no frame", d);
            end else begin
                chk("frame_a", 32'(d), 32'(exp_a.pop_front()));
            end
        end
        mon_tick(mon_b, 8, 1, ifb.nCS, ifb.SCK, ifb.MOSI, done, d);
        if (done) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL frame_b: got 0x%0h, expected no frame", d);
            end else begin
                chk("frame_b", 32'(d), 32'(exp_b.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [15:0] d, input logic exp_rdy, input logic rec);
        ifa.wr_valid = 1'b1;
        ifa.wr_data  = d;
        chk("wr_ready_a", 32'(ifa.wr_ready), 32'(exp_rdy));
        if (exp_rdy && rec) exp_a.push_back(d);
        cyc();
    endtask

    task automatic drive_b(input logic [7:0] d);
        ifb.wr_valid = 1'b1;
        ifb.wr_data  = d;
        chk("wr_ready_b", 32'(ifb.wr_ready), 32'd1);
        exp_b.push_back(16'(d));
        cyc();
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while ((ifa.busy || ifa.fifo_level != 0 || !ifa.nCS) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout_a: still busy after %0d cycles, expected idle", n);
        end
        repeat (2) cyc();
    endtask

    task automatic wait_idle_b(input int budget);
        int n = 0;
        while ((ifb.busy || ifb.fifo_level != 0 || !ifb.nCS) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout_b: still busy after %0d cycles, expected idle", n);
        end
        repeat (2) cyc();
    endtask

    initial begin
        int n;
        int len;
        mon_init(mon_a);
        mon_init(mon_b);
        rst = 1'b1;
        ifa.wr_valid = 1'b0; ifa.wr_data = '0;
        ifb.wr_valid = 1'b0; ifb.wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset_ncs", 32'(ifa.nCS), 32'd1);
        chk("reset_sck", 32'(ifa.SCK), 32'd0);
        chk("reset_mosi", 32'(ifa.MOSI), 32'd0);
        chk("reset_busy", 32'(ifa.busy), 32'd0);
        chk("reset_wr_ready", 32'(ifa.wr_ready), 32'd1);
        chk("reset_level", 32'(ifa.fifo_level), 32'd0);

        // Single frame: two-cycle latency to nCS low, busy for SETUP..GAP
        drive_a(16'h0305, 1'b1, 1'b1);
        ifa.wr_valid = 1'b0;
        chk("ncs_high_after_push", 32'(ifa.nCS), 32'd1);
        cyc();
        chk("ncs_low_after_pop", 32'(ifa.nCS), 32'd0);
        n = 0;
        while (ifa.busy && n < 1000) begin
            n++;
            cyc();
        end
        chk("busy_cycles", 32'(n), 32'd68);
        chk("idle_ncs", 32'(ifa.nCS), 32'd1);
        chk("idle_sck", 32'(ifa.SCK), 32'd0);
        chk("idle_mosi", 32'(ifa.MOSI), 32'd0);
        repeat (2) cyc();

        // Back-to-back frames
        drive_a(16'hA5A5, 1'b1, 1'b1);
        chk("b2b_level_1", 32'(ifa.fifo_level), 32'd1);
        drive_a(16'h5A5A, 1'b1, 1'b1);
        chk("b2b_level_2", 32'(ifa.fifo_level), 32'd1);
        ifa.wr_valid = 1'b0;
        wait_idle_a(1000);
        chk("b2b_level_end", 32'(ifa.fifo_level), 32'd0);
        chk("b2b_ncs_gap", 32'(mon_a.last_gap), 32'd2);

        // FIFO full: sixth push is refused
        for (int i = 1; i <= 6; i++) drive_a(16'(i), (i <= 5), 1'b1);
        ifa.wr_valid = 1'b0;
        wait_idle_a(2000);

        // clk_div=1, width=8
        drive_b(8'h81);
        ifb.wr_valid = 1'b0;
        wait_idle_b(200);
        chk("b_sck_map", mon_b.last_map, 32'h0000AAAA);

        // Random bursts on both ports, at most four frames each from idle
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) drive_a(16'($urandom), 1'b1, 1'b1);
            ifa.wr_valid = 1'b0;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) drive_b(8'($urandom_range(0, 255)));
            ifb.wr_valid = 1'b0;
            wait_idle_a(2000);
            wait_idle_b(500);
        end

        // Reset mid-frame with two frames queued
        allow_abort = 1'b1;
        drive_a(16'hFFFF, 1'b1, 1'b0);
        drive_a(16'h1111, 1'b1, 1'b0);
        drive_a(16'h2222, 1'b1, 1'b0);
        ifa.wr_valid = 1'b0;
        n = 0;
        while (mon_a.rises != 7 && n < 500) begin
            cyc();
            n++;
        end
        chk("reach_7th_rise", 32'(mon_a.rises), 32'd7);
        rst = 1'b1;
        #1;
        chk("rst_ncs", 32'(ifa.nCS), 32'd1);
        chk("rst_sck", 32'(ifa.SCK), 32'd0);
        chk("rst_mosi", 32'(ifa.MOSI), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_level", 32'(ifa.fifo_level), 32'd0);
        chk("post_rst_wr_ready", 32'(ifa.wr_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (ifa.SCK || !ifa.nCS) n++;
            cyc();
        end
        chk("post_rst_quiet", 32'(n), 32'd0);
        allow_abort = 1'b0;

        // Operation resumes after reset
        drive_a(16'h1234, 1'b1, 1'b1);
        ifa.wr_valid = 1'b0;
        wait_idle_a(500);

        chk("exp_a_drained", 32'(exp_a.size()), 32'd0);
        chk("exp_b_drained", 32'(exp_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
